// File: rtl/wta_disparity_select.sv
// Winner-take-all disparity selector: per-beat argmin over NUM_CH window sums, merged
// with a per-pixel running best/second-best held in a line RAM across PASSES sweeps.
module wta_disparity_select #(
    parameter int NUM_CH = 4,
    parameter int WS_W   = 14,
    parameter int DISP_W = 6,
    parameter int PIXELS = 640,
    parameter int PASSES = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     ws_valid,
    input  logic [NUM_CH*WS_W-1:0]   ws_in,
    input  logic [DISP_W-1:0]        base_disp,
    input  logic                     uniq_en,
    input  logic [WS_W-1:0]          uniq_thresh,
    output logic                     out_valid,
    output logic [DISP_W-1:0]        out_disp,
    output logic [WS_W-1:0]          out_ws,
    output logic                     out_conf_ok,
    output logic                     busy,
    output logic                     err_overrun
);
    localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    typedef struct packed {
        logic [WS_W-1:0]   best;
        logic [WS_W-1:0]   second;
        logic [DISP_W-1:0] disp;
    } entry_t;

    state_t              state_reg, state_next;
    logic                drain_reg;
    logic [PIX_W-1:0]    pix_cnt_reg;
    logic [PASS_W-1:0]   pass_cnt_reg;
    logic                accept, last_pix, last_pass;

    assign accept    = ws_valid && (state_reg == ACCUM);
    assign last_pix  = (pix_cnt_reg == PIX_W'(PIXELS - 1));
    assign last_pass = (pass_cnt_reg == PASS_W'(PASSES - 1));
    assign busy      = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (accept && last_pix && last_pass) state_next = DRAIN;
            DRAIN:   if (drain_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            drain_reg    <= 1'b0;
            pix_cnt_reg  <= '0;
            pass_cnt_reg <= '0;
            err_overrun  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            drain_reg   <= (state_reg == DRAIN) && !drain_reg;
            err_overrun <= start && (state_reg != IDLE);
            if (state_reg == IDLE && start) begin
                pix_cnt_reg  <= '0;
                pass_cnt_reg <= '0;
            end else if (accept) begin
                if (last_pix) begin
                    pix_cnt_reg  <= '0;
                    pass_cnt_reg <= last_pass ? '0 : pass_cnt_reg + PASS_W'(1);
                end else begin
                    pix_cnt_reg <= pix_cnt_reg + PIX_W'(1);
                end
            end
        end
    end

    logic [WS_W-1:0] ch_ws [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_ws[gi] = ws_in[gi*WS_W +: WS_W];
        end
    endgenerate

    // Lowest-index channel wins ties because only a strict less-than displaces the minimum.
    logic [WS_W-1:0]  beat_min, beat_min2;
    logic [IDX_W-1:0] beat_idx;

    always_comb begin
        beat_min  = ch_ws[0];
        beat_min2 = '1;
        beat_idx  = '0;
        for (int c = 1; c < NUM_CH; c++) begin
            if (ch_ws[c] < beat_min) begin
                beat_min2 = beat_min;
                beat_min  = ch_ws[c];
                beat_idx  = IDX_W'(c);
            end else if (ch_ws[c] < beat_min2) begin
                beat_min2 = ch_ws[c];
            end
        end
    end

    logic              s1_valid, s1_first, s1_last, s1_uen;
    logic [WS_W-1:0]   s1_m, s1_m2, s1_thr;
    logic [DISP_W-1:0] s1_disp;
    logic [PIX_W-1:0]  s1_addr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_uen   <= 1'b0;
            s1_m     <= '0;
            s1_m2    <= '0;
            s1_thr   <= '0;
            s1_disp  <= '0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_first <= (pass_cnt_reg == '0);
                s1_last  <= last_pass;
                s1_uen   <= uniq_en;
                s1_m     <= beat_min;
                s1_m2    <= beat_min2;
                s1_thr   <= uniq_thresh;
                s1_disp  <= base_disp + DISP_W'(beat_idx);
                s1_addr  <= pix_cnt_reg;
            end
        end
    end

    // Line RAM: read issued with the beat, write-back one cycle after the read data returns.
    entry_t ram [PIXELS];
    entry_t rd_data;
    entry_t merged;

    always_comb begin
        merged = rd_data;
        if (s1_first) begin
            merged.best   = s1_m;
            merged.second = s1_m2;
            merged.disp   = s1_disp;
        end else if (s1_m < rd_data.best) begin
            merged.best   = s1_m;
            merged.second = (rd_data.best < s1_m2) ? rd_data.best : s1_m2;
            merged.disp   = s1_disp;
        end else begin
            merged.second = (rd_data.second < s1_m) ? rd_data.second : s1_m;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) rd_data <= ram[pix_cnt_reg];
        if (s1_valid) ram[s1_addr] <= merged;
    end

    logic [WS_W:0] margin;
    assign margin = {1'b0, merged.second} - {1'b0, merged.best};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_disp    <= '0;
            out_ws      <= '0;
            out_conf_ok <= 1'b0;
        end else begin
            out_valid <= s1_valid && s1_last;
            if (s1_valid && s1_last) begin
                out_disp    <= merged.disp;
                out_ws      <= merged.best;
                out_conf_ok <= !s1_uen || (margin > {1'b0, s1_thr});
            end
        end
    end
endmodule

// File: tb/tb_wta_disparity_select.sv
// Scoreboard bench for wta_disparity_select: directed line vectors with hand-computed winners.
module tb_wta_disparity_select;
    localparam int NUM_CH = 4, WS_W = 14, DISP_W = 6, PIXELS = 4, PASSES = 2;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   start = 1'b0;
    logic                   ws_valid = 1'b0;
    logic [NUM_CH*WS_W-1:0] ws_in = '0;
    logic [DISP_W-1:0]      base_disp = '0;
    logic                   uniq_en = 1'b0;
    logic [WS_W-1:0]        uniq_thresh = '0;
    logic                   out_valid, out_conf_ok, busy, err_overrun;
    logic [DISP_W-1:0]      out_disp;
    logic [WS_W-1:0]        out_ws;

    wta_disparity_select #(
        .NUM_CH(NUM_CH), .WS_W(WS_W), .DISP_W(DISP_W), .PIXELS(PIXELS), .PASSES(PASSES)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .ws_valid(ws_valid),
        .ws_in(ws_in), .base_disp(base_disp), .uniq_en(uniq_en), .uniq_thresh(uniq_thresh),
        .out_valid(out_valid), .out_disp(out_disp), .out_ws(out_ws),
        .out_conf_ok(out_conf_ok), .busy(busy), .err_overrun(err_overrun)
    );

    always #5 clock = ~clock;

    typedef struct {int disp; int ws; int conf;} exp_t;
    exp_t q[$];

    int checks = 0, passes = 0, strobe_cnt = 0, err_cnt = 0;

    logic [NUM_CH*WS_W-1:0] tab_ws [0:1][0:1][0:3];
    int exp_disp [0:1][0:3];
    int exp_ws   [0:1][0:3];
    int exp_cu   [0:1][0:3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [NUM_CH*WS_W-1:0] pk(input int a, input int b, input int c, input int d);
        return {WS_W'(d), WS_W'(c), WS_W'(b), WS_W'(a)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops the scoreboard on every strobe, checks zeroed outputs while in reset.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                chk("reset_outputs", int'({out_valid, busy, err_overrun, out_conf_ok, out_disp, out_ws}), 0);
            end else begin
                if (err_overrun) err_cnt++;
                if (out_valid) begin
                    strobe_cnt++;
                    if (q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_out_valid: got disp %0d ws %0d with empty scoreboard", out_disp, out_ws);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        $display("out: disp %0d ws %0d conf %0d (exp %0d %0d %0d)",
                                 out_disp, out_ws, out_conf_ok, e.disp, e.ws, e.conf);
                        chk("out_disp", int'(out_disp), e.disp);
                        chk("out_ws", int'(out_ws), e.ws);
                        chk("out_conf_ok", int'(out_conf_ok), e.conf);
                    end
                end
            end
        end
    end

    task automatic run_line(input int l, input bit uen, input bit gaps, input bit ovr);
        int s0, e0;
        exp_t e;
        s0 = strobe_cnt;
        e0 = err_cnt;
        uniq_en = uen;
        uniq_thresh = 14'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < PASSES; p++) begin
            for (int x = 0; x < PIXELS; x++) begin
                if (gaps) begin
                    int g;
                    g = $urandom_range(0, 2);
                    for (int k = 0; k < g; k++) begin
                        ws_valid = 1'b0;
                        tick();
                    end
                end
                if (ovr && p == 0 && x == 2) begin
                    ws_valid = 1'b0;
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                    @(negedge clock);
                    chk("err_overrun_pulse", int'(err_overrun), 1);
                    chk("busy_in_accum", int'(busy), 1);
                end
                if (p == PASSES - 1) begin
                    e.disp = exp_disp[l][x];
                    e.ws = exp_ws[l][x];
                    e.conf = uen ? exp_cu[l][x] : 1;
                    q.push_back(e);
                end
                ws_in = tab_ws[l][p][x];
                base_disp = DISP_W'(4 * p);
                ws_valid = 1'b1;
                tick();
            end
        end
        ws_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("last_strobe_latency", int'(out_valid), 1);
        chk("busy_at_last_strobe", int'(busy), 1);
        repeat (2) @(negedge clock);
        chk("busy_after_drain", int'(busy), 0);
        chk("strobes_per_line", strobe_cnt - s0, PIXELS);
        chk("scoreboard_drained", q.size(), 0);
        chk("err_overrun_count", err_cnt - e0, ovr ? 1 : 0);
        q.delete();
    endtask

    initial begin
        // Line A: hand-computed winners, uniqueness with thresh 5.
        tab_ws[0][0][0] = pk(40, 10, 30, 20);       tab_ws[0][1][0] = pk(50, 60, 15, 70);
        tab_ws[0][0][1] = pk(9, 9, 9, 9);           tab_ws[0][1][1] = pk(9, 9, 9, 9);
        tab_ws[0][0][2] = pk(100, 200, 300, 400);   tab_ws[0][1][2] = pk(104, 500, 600, 700);
        tab_ws[0][0][3] = pk(300, 106, 100, 250);   tab_ws[0][1][3] = pk(400, 500, 600, 700);
        exp_disp[0] = '{1, 0, 0, 2};  exp_ws[0] = '{10, 9, 100, 100};  exp_cu[0] = '{0, 0, 0, 1};
        // Line B: later-pass wins, full-scale sums, cross-pass ties.
        tab_ws[1][0][0] = pk(40, 10, 30, 20);       tab_ws[1][1][0] = pk(50, 60, 5, 70);
        tab_ws[1][0][1] = pk(9, 9, 9, 9);           tab_ws[1][1][1] = pk(9, 9, 9, 9);
        tab_ws[1][0][2] = pk(16383, 16383, 16383, 16383); tab_ws[1][1][2] = pk(16383, 16383, 16383, 0);
        tab_ws[1][0][3] = pk(70, 60, 50, 40);       tab_ws[1][1][3] = pk(40, 41, 42, 43);
        exp_disp[1] = '{6, 0, 7, 3};  exp_ws[1] = '{5, 9, 0, 40};  exp_cu[1] = '{0, 0, 1, 0};

        repeat (3) tick();
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_busy", int'(busy), 0);
        chk("idle_out_valid", int'(out_valid), 0);

        run_line(0, 1'b1, 1'b0, 1'b0);
        run_line(0, 1'b1, 1'b1, 1'b0);
        run_line(1, 1'b0, 1'b0, 1'b0);
        run_line(1, 1'b1, 1'b1, 1'b0);

        // ws_valid while idle must be ignored.
        for (int k = 0; k < 3; k++) begin
            ws_in = pk(1, 1, 1, 1);
            ws_valid = 1'b1;
            tick();
        end
        ws_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("idle_beats_no_busy", int'(busy), 0);
        run_line(0, 1'b0, 1'b0, 1'b1);

        // Abort a line with reset during pass 1 pixel 2, then run a fresh line.
        uniq_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int x = 0; x < PIXELS; x++) begin
            ws_in = tab_ws[0][0][x];
            base_disp = '0;
            ws_valid = 1'b1;
            tick();
        end
        for (int x = 0; x < 2; x++) begin
            exp_t e;
            e.disp = exp_disp[0][x];
            e.ws = exp_ws[0][x];
            e.conf = 1;
            q.push_back(e);
            ws_in = tab_ws[0][1][x];
            base_disp = DISP_W'(4);
            tick();
        end
        ws_valid = 1'b0;
        repeat (3) tick();
        chk("pre_reset_drained", q.size(), 0);
        ws_in = tab_ws[0][1][2];
        ws_valid = 1'b1;
        reset_n = 1'b0;
        repeat (2) tick();
        ws_valid = 1'b0;
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        chk("post_reset_busy", int'(busy), 0);
        run_line(1, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
